// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N:1 registered mux with round-robin arbitration.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Index increment that wraps to 0 after n-1; valid for any n, not just powers of 2.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/mux_nto1_rr_arbiter.sv
// Combinational rotate-priority picker: first asserted request at or after ptr, wrapping.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int unsigned CHANNELS = 4,
    localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic [SEL_W-1:0]    grant,
    output logic                grant_valid
);

    localparam logic [SEL_W:0] CH_N = (SEL_W+1)'(CHANNELS);

    logic [SEL_W:0] idx;

    // One extra bit holds ptr+i before the modulo fold, so odd channel counts wrap exactly.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            idx = {1'b0, ptr} + (SEL_W+1)'(i);
            if (idx >= CH_N) begin
                idx = idx - CH_N;
            end
            if (!grant_valid && req[idx[SEL_W-1:0]]) begin
                grant       = idx[SEL_W-1:0];
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_nto1_rr.sv
// N:1 mux with fixed or round-robin select, one registered output stage, valid/ready handshake.
module mux_nto1_rr
    import mux_pkg::*;
#(
    parameter  int unsigned WIDTH    = 8,
    parameter  int unsigned CHANNELS = 4,
    localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [CHANNELS*WIDTH-1:0] i_data,
    input  logic [CHANNELS-1:0]       i_valid,
    output logic [CHANNELS-1:0]       o_ready,
    input  logic                      i_mode,
    input  logic [SEL_W-1:0]          i_sel,
    output logic [WIDTH-1:0]          o_data,
    output logic [SEL_W-1:0]          o_chan,
    output logic                      o_valid,
    input  logic                      i_ready
);

    localparam logic [SEL_W:0] CH_N = (SEL_W+1)'(CHANNELS);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] rr_grant;
    logic             rr_valid;
    logic [SEL_W-1:0] grant;
    logic             grant_valid;
    logic             load_en;
    logic [WIDTH-1:0] chan_data [CHANNELS];

    rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
        .req         (i_valid),
        .ptr         (ptr),
        .grant       (rr_grant),
        .grant_valid (rr_valid)
    );

    always_comb begin
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            chan_data[k] = i_data[k*WIDTH +: WIDTH];
        end
    end

    // Mode mux; an out-of-range fixed select simply never grants.
    always_comb begin
        grant       = rr_grant;
        grant_valid = rr_valid;
        if (i_mode == MODE_FIXED) begin
            grant       = i_sel;
            grant_valid = ({1'b0, i_sel} < CH_N) && i_valid[i_sel];
        end
    end

    assign load_en = !o_valid || i_ready;

    always_comb begin
        o_ready = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            o_ready[k] = i_rst_n && load_en && grant_valid && (grant == SEL_W'(k));
        end
    end

    // Output stage and RR pointer; the pointer only advances on an RR transfer in.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_chan  <= '0;
            ptr     <= '0;
        end else if (load_en) begin
            if (grant_valid) begin
                o_valid <= 1'b1;
                o_data  <= chan_data[grant];
                o_chan  <= grant;
                if (i_mode == MODE_RR) begin
                    ptr <= SEL_W'(wrap_inc(32'(grant), CHANNELS));
                end
            end else begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule
